// File: rtl/stopwatch_pkg.sv
// Shared encodings for the stopwatch input controller: mode codes, pause FSM
// states and the default debounce length.
package stopwatch_pkg;

    localparam logic [1:0] MODE_NORMAL  = 2'b00;
    localparam logic [1:0] MODE_ADJ_MIN = 2'b01;
    localparam logic [1:0] MODE_ADJ_SEC = 2'b10;

    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } pause_state_e;

endpackage

// File: rtl/debounce_sync.sv
// One debounce channel: 2-flop synchroniser, stability counter, stable level
// and a registered 0->1 pulse that coincides with the level update.
module debounce_sync #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             rise_q,  rise_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/stopwatch_input_ctrl.sv
// Board-input conditioning for the stopwatch: debounced buttons/switches,
// RUN/PAUSED state, mode register and gated count/adjust enables.
module stopwatch_input_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       sw_sel,
    input  logic       sw_adj,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    output logic       count_en,
    output logic       adj_en,
    output logic       adj_sel,
    output logic       clr,
    output logic       paused,
    output logic [1:0] mode
);

    logic pause_rise, reset_rise;
    logic pause_level_unused, reset_level_unused;
    logic sel_level, adj_level;
    logic sel_rise_unused, adj_rise_unused;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_pause (
        .clk(clk), .rst(rst), .din(btn_pause), .level(pause_level_unused), .rise(pause_rise)
    );
    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_reset (
        .clk(clk), .rst(rst), .din(btn_reset), .level(reset_level_unused), .rise(reset_rise)
    );
    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sel (
        .clk(clk), .rst(rst), .din(sw_sel), .level(sel_level), .rise(sel_rise_unused)
    );
    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_adj (
        .clk(clk), .rst(rst), .din(sw_adj), .level(adj_level), .rise(adj_rise_unused)
    );

    pause_state_e state_q, state_d;
    logic         clr_q, clr_d;
    logic [1:0]   mode_q, mode_d;
    logic         adj_sel_q, adj_sel_d;
    logic         count_en_q, count_en_d;
    logic         adj_en_q, adj_en_d;

    always_comb begin
        state_d    = state_q;
        clr_d      = reset_rise;
        adj_sel_d  = sel_level;
        mode_d     = MODE_NORMAL;
        count_en_d = 1'b0;
        adj_en_d   = 1'b0;

        // reset button wins over a simultaneous pause press
        if (reset_rise) begin
            state_d = ST_RUN;
        end else if (pause_rise) begin
            state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
        end

        if (adj_level) begin
            mode_d = sel_level ? MODE_ADJ_SEC : MODE_ADJ_MIN;
        end

        // gating uses registered state; a failed tick is simply dropped
        if (state_q == ST_RUN && !clr_q) begin
            count_en_d = tick_1hz && (mode_q == MODE_NORMAL);
            adj_en_d   = tick_2hz && (mode_q != MODE_NORMAL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            clr_q      <= 1'b0;
            mode_q     <= MODE_NORMAL;
            adj_sel_q  <= 1'b0;
            count_en_q <= 1'b0;
            adj_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_q      <= clr_d;
            mode_q     <= mode_d;
            adj_sel_q  <= adj_sel_d;
            count_en_q <= count_en_d;
            adj_en_q   <= adj_en_d;
        end
    end

    assign count_en = count_en_q;
    assign adj_en   = adj_en_q;
    assign adj_sel  = adj_sel_q;
    assign clr      = clr_q;
    assign paused   = (state_q == ST_PAUSED);
    assign mode     = mode_q;

endmodule

// File: doc/stopwatch_input_ctrl.md
# stopwatch_input_ctrl

Conditions the stopwatch's raw board inputs and turns them into clean control for the time-keeping counter stage. It takes two push-buttons (pause, reset) and two slide switches (select, adjust), plus the 1 Hz and 2 Hz enable ticks from the clock generator. Inputs are synchronised and debounced, and a RUN/PAUSED state machine is kept. Outputs are single-cycle count/adjust enables and a clear pulse that the digit counters consume directly.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable `clk` cycles required before a debounced level changes (10 ms at 100 MHz). Minimum 2.
- `CNT_W`, default 20: debounce counter width. Must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.

Ports:
- `clk`  in  1  system clock, 100 MHz. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `btn_pause`  in  1  raw, asynchronous, bouncing push-button.
- `btn_reset`  in  1  raw, asynchronous, bouncing push-button.
- `sw_sel`  in  1  raw slide switch: 0 = minutes, 1 = seconds.
- `sw_adj`  in  1  raw slide switch: 1 = adjust mode.
- `tick_1hz`  in  1  one-`clk`-wide pulse, 1 Hz, already in the `clk` domain.
- `tick_2hz`  in  1  one-`clk`-wide pulse, 2 Hz, already in the `clk` domain.
- `count_en`  out  1  one-cycle pulse: advance the stopwatch by 1 s.
- `adj_en`  out  1  one-cycle pulse: increment the selected field.
- `adj_sel`  out  1  field to adjust: 0 = minutes, 1 = seconds. Meaningful only while `mode` ≠ NORMAL.
- `clr`  out  1  one-cycle pulse: clear all digits to 00:00.
- `paused`  out  1  level: stopwatch is paused.
- `mode`  out  2  00 = NORMAL, 01 = ADJ_MIN, 10 = ADJ_SEC. 11 is never driven.

## Operation
- Each of the 4 raw inputs has its own debounce channel:
  - 2-flop synchroniser.
  - Counter of consecutive cycles where the synchronised value ≠ the stable level.
  - The counter resets to 0 on any cycle where the two are equal.
- When the counter reaches DEBOUNCE_CYCLES−1 and the values still differ:
  - the stable level takes the synchronised value;
  - the counter returns to 0;
  - the channel's `rise` pulse is asserted for exactly that one cycle, but only on a 0→1 change.
- Glitches shorter than DEBOUNCE_CYCLES cycles never change a stable level.
- Pause state machine, 2 states, reset state RUN:
  - RUN → PAUSED on a pause `rise`.
  - PAUSED → RUN on a pause `rise`.
  - A reset `rise` forces RUN. It has priority over a pause `rise` in the same cycle.
- `clr` is the reset `rise`, registered once.
- `mode` is registered from the stable switch levels:
  - stable adj = 0 → NORMAL;
  - stable adj = 1 and stable sel = 0 → ADJ_MIN;
  - stable adj = 1 and stable sel = 1 → ADJ_SEC.
- `adj_sel` is the stable sel level, registered alongside `mode`.
- `count_en` is registered from `tick_1hz` AND `mode` == NORMAL AND NOT `paused` AND NOT `clr`.
- `adj_en` is registered from `tick_2hz` AND `mode` ≠ NORMAL AND NOT `paused` AND NOT `clr`.
- `count_en` and `adj_en` are mutually exclusive by construction.
- On any `tick_1hz` or `tick_2hz` where the enabling conditions fail, the tick is dropped, not queued.

## Timing
- Reset values: every output is 0 (`mode` = NORMAL, `paused` = 0). All stable levels, synchronisers and counters are also 0.
- A raw input change that then stays constant updates its stable level at clock edge 2+DEBOUNCE_CYCLES after the first sampling edge. The `rise` pulse occurs in the same cycle.
- Latency from `rise` to outputs is 1 cycle each for:
  - `paused` toggle;
  - `clr` pulse;
  - `mode`/`adj_sel` update.
- Tick → `count_en`/`adj_en`: 1 cycle. Output width is always exactly 1 cycle.
- Enable gating uses the registered `paused` and `mode` values at the time the tick arrives.
- A button still held when `rst` deasserts is seen as a 0→1 change. It yields a `rise` DEBOUNCE_CYCLES+2 edges later. This is intended.
- A button held for any length of time produces exactly one `rise`. Release produces none.
- `rst` asserted mid-debounce discards the partial count. No pulse is emitted in the cycle after reset.

## Structure
- Shared package `stopwatch_pkg`:
  - `mode` encoding constants MODE_NORMAL, MODE_ADJ_MIN, MODE_ADJ_SEC;
  - pause-FSM state constants;
  - default DEBOUNCE_CYCLES.
- One sub-module, `debounce_sync`:
  - parameters DEBOUNCE_CYCLES and CNT_W;
  - ports `clk`, `rst`, `din`, `level`, `rise`;
  - instantiated 4 times.
- Top level holds the pause FSM, mode register and enable gating.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
1. Apply `rst` for 3 cycles → all outputs 0 and `mode` = 00. Then 20 `tick_1hz` pulses → 20 `count_en` pulses, each 1 cycle after its tick.
2. `btn_pause` bounces 1,0,1,0 (1 cycle each), then holds 1 for 50 cycles → exactly one `rise`. `paused` = 1 at edge 7 after the final 0→1. Subsequent `tick_1hz` produce no `count_en`.
3. Pause `rise` and reset `rise` arranged in the same cycle while PAUSED → `paused` = 0 and `clr` = 1 for one cycle. No `count_en` on a tick coinciding with `clr`.
4. Set `sw_adj` = 1, `sw_sel` = 1, both stable → `mode` = 10 and `adj_sel` = 1. `tick_1hz` is ignored. Each `tick_2hz` gives `adj_en` 1 cycle later. Toggle `sw_sel` → `mode` = 01 after 7 cycles.
5. Hold `btn_reset` = 1 through `rst` deassert → a single `clr` pulse 7 edges after deassert. None on release.
6. Assert `rst` 2 cycles into a debounce of `btn_pause` → no `rise`, `paused` stays 0.
